// File: rtl/regop_pkg.sv
// Shared definitions for the register-to-register execute unit: op/shift codes,
// FSM state encoding and status bit positions.
package regop_pkg;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_AND = 2'b10;
  localparam logic [1:0] OP_MVN = 2'b11;

  localparam logic [1:0] SH_NONE = 2'b00;
  localparam logic [1:0] SH_LSL1 = 2'b01;
  localparam logic [1:0] SH_LSR1 = 2'b10;
  localparam logic [1:0] SH_ASR1 = 2'b11;

  localparam int STAT_Z = 2;
  localparam int STAT_N = 1;
  localparam int STAT_V = 0;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_READ_A = 3'd1,
    ST_READ_B = 3'd2,
    ST_EXEC   = 3'd3,
    ST_WRITE  = 3'd4,
    ST_DONE   = 3'd5
  } state_t;

endpackage

// File: rtl/regop_alu_shift.sv
// Combinational shifter + ALU: shifts B by one position, applies the op to A and
// the shifted B, and derives Z/N/V from the truncated result.
module regop_alu_shift
  import regop_pkg::*;
#(
  parameter int DATA_W = 16
) (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [1:0]        op,
  input  logic [1:0]        shift,
  output logic [DATA_W-1:0] c,
  output logic              z,
  output logic              n,
  output logic              v
);

  logic [DATA_W-1:0] b_sh;

  always_comb begin
    b_sh = b;
    case (shift)
      SH_LSL1: b_sh = {b[DATA_W-2:0], 1'b0};
      SH_LSR1: b_sh = {1'b0, b[DATA_W-1:1]};
      SH_ASR1: b_sh = {b[DATA_W-1], b[DATA_W-1:1]};
      default: b_sh = b;
    endcase
  end

  // Overflow only exists for ADD/SUB; it compares operand signs with the result sign.
  always_comb begin
    c = '0;
    v = 1'b0;
    case (op)
      OP_ADD: begin
        c = a + b_sh;
        v = (a[DATA_W-1] == b_sh[DATA_W-1]) && (c[DATA_W-1] != a[DATA_W-1]);
      end
      OP_SUB: begin
        c = a - b_sh;
        v = (a[DATA_W-1] != b_sh[DATA_W-1]) && (c[DATA_W-1] != a[DATA_W-1]);
      end
      OP_AND:  c = a & b_sh;
      default: c = ~b_sh;
    endcase
  end

  assign z = (c == '0);
  assign n = c[DATA_W-1];

endmodule

// File: rtl/regop_sequencer.sv
// Multi-cycle execute unit wrapped around an 8x16 register file: reads Rn then Rm,
// executes, optionally writes Rd, and pulses done.
module regop_sequencer
  import regop_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int REG_AW = 3
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  output logic              ready,
  input  logic [1:0]        op,
  input  logic [1:0]        shift,
  input  logic [REG_AW-1:0] rn,
  input  logic [REG_AW-1:0] rm,
  input  logic [REG_AW-1:0] rd,
  input  logic              wb_en,
  output logic [REG_AW-1:0] readnum,
  output logic [REG_AW-1:0] writenum,
  output logic              write,
  output logic [DATA_W-1:0] data_in,
  input  logic [DATA_W-1:0] data_out,
  output logic [DATA_W-1:0] result,
  output logic [2:0]        status,
  output logic              done,
  output logic [2:0]        dbg_state
);

  state_t            state;
  logic [1:0]        op_q;
  logic [1:0]        shift_q;
  logic [REG_AW-1:0] rn_q;
  logic [REG_AW-1:0] rm_q;
  logic [REG_AW-1:0] rd_q;
  logic              wb_q;
  logic [DATA_W-1:0] a_q;
  logic [DATA_W-1:0] b_q;
  logic [DATA_W-1:0] c_q;
  logic [2:0]        status_q;
  logic [DATA_W-1:0] alu_c;
  logic              alu_z;
  logic              alu_n;
  logic              alu_v;

  regop_alu_shift #(.DATA_W(DATA_W)) u_alu (
    .a     (a_q),
    .b     (b_q),
    .op    (op_q),
    .shift (shift_q),
    .c     (alu_c),
    .z     (alu_z),
    .n     (alu_n),
    .v     (alu_v)
  );

  // Handshake: a command transfers on a rising edge where start && ready; ready is
  // high only in IDLE, and start seen in any other state is dropped (no queueing).
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= ST_IDLE;
      op_q     <= '0;
      shift_q  <= '0;
      rn_q     <= '0;
      rm_q     <= '0;
      rd_q     <= '0;
      wb_q     <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      c_q      <= '0;
      status_q <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            op_q    <= op;
            shift_q <= shift;
            rn_q    <= rn;
            rm_q    <= rm;
            rd_q    <= rd;
            wb_q    <= wb_en;
            state   <= ST_READ_A;
          end
        end
        ST_READ_A: begin
          a_q   <= data_out;
          state <= ST_READ_B;
        end
        ST_READ_B: begin
          b_q   <= data_out;
          state <= ST_EXEC;
        end
        ST_EXEC: begin
          c_q              <= alu_c;
          status_q[STAT_Z] <= alu_z;
          status_q[STAT_N] <= alu_n;
          status_q[STAT_V] <= alu_v;
          state            <= wb_q ? ST_WRITE : ST_DONE;
        end
        ST_WRITE: state <= ST_DONE;
        default:  state <= ST_IDLE;
      endcase
    end
  end

  // Register-file controls decode straight from state so a reset drops write at once.
  assign ready     = (state == ST_IDLE);
  assign readnum   = (state == ST_READ_A) ? rn_q :
                     (state == ST_READ_B) ? rm_q : '0;
  assign writenum  = (state == ST_WRITE) ? rd_q : '0;
  assign write     = (state == ST_WRITE);
  assign data_in   = c_q;
  assign done      = (state == ST_DONE);
  assign result    = c_q;
  assign status    = status_q;
  assign dbg_state = state;

endmodule
